// File: rtl/frame_timer_pkg.sv
// Shared types and constants for the frame event timer: the default 60 Hz divider,
// the per-channel state encoding and the prescaler width helper.
package frame_timer_pkg;

  localparam int unsigned FRAME_DIV_60HZ = 833334;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  localparam int unsigned PRESC_W_60HZ = presc_width(FRAME_DIV_60HZ);

endpackage

// File: rtl/frame_channel.sv
// One frame-count timer: counts frame ticks down from a loaded value and pulses
// o_expired when the last tick is consumed, optionally reloading for periodic use.
module frame_channel
  import frame_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_periodic,
  input  logic             i_stop,
  output logic             o_expired,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  chan_state_t      r_state,    w_state_n;
  logic [CNT_W-1:0] r_count,    w_count_n;
  logic [CNT_W-1:0] r_reload,   w_reload_n;
  logic             r_periodic, w_periodic_n;
  logic             r_expired,  w_expired_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_count    <= w_count_n;
      r_reload   <= w_reload_n;
      r_periodic <= w_periodic_n;
      r_expired  <= w_expired_n;
    end
  end

  // Load outranks the tick so a load landing on a tick still counts all V frames.
  always_comb begin
    w_state_n    = r_state;
    w_count_n    = r_count;
    w_reload_n   = r_reload;
    w_periodic_n = r_periodic;
    w_expired_n  = 1'b0;
    if (i_stop || (i_load && (i_load_val == '0))) begin
      w_state_n = IDLE;
      w_count_n = '0;
    end else if (i_load) begin
      w_state_n    = RUN;
      w_count_n    = i_load_val;
      w_reload_n   = i_load_val;
      w_periodic_n = i_periodic;
    end else if ((r_state == RUN) && i_tick) begin
      if (r_count > CNT_W'(1)) begin
        w_count_n = r_count - CNT_W'(1);
      end else if (r_periodic) begin
        w_count_n   = r_reload;
        w_expired_n = 1'b1;
      end else begin
        w_count_n   = '0;
        w_state_n   = IDLE;
        w_expired_n = 1'b1;
      end
    end
  end

  assign o_expired = r_expired;
  assign o_busy    = (r_state == RUN);
  assign o_count   = r_count;

endmodule

// File: rtl/frame_event_timer.sv
// Frame-rate prescaler plus CHANNELS independent frame-count timers driven by
// its one-cycle frame tick.
module frame_event_timer
  import frame_timer_pkg::*;
#(
  parameter int unsigned DIV      = FRAME_DIV_60HZ,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       ch_load,
  input  logic [CHANNELS*CNT_W-1:0] ch_load_val,
  input  logic [CHANNELS-1:0]       ch_periodic,
  input  logic [CHANNELS-1:0]       ch_stop,
  output logic                      frame_tick,
  output logic [CHANNELS-1:0]       ch_expired,
  output logic [CHANNELS-1:0]       ch_busy,
  output logic [CHANNELS*CNT_W-1:0] ch_count
);

  localparam int unsigned PW = presc_width(DIV);

  logic [PW-1:0] r_presc;
  logic          r_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= PW'(DIV - 1);
      r_tick  <= 1'b0;
    end else if (enable) begin
      if (r_presc == '0) begin
        r_presc <= PW'(DIV - 1);
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc - PW'(1);
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign frame_tick = r_tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    frame_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_tick     (r_tick),
      .i_load     (ch_load[g]),
      .i_load_val (ch_load_val[g*CNT_W +: CNT_W]),
      .i_periodic (ch_periodic[g]),
      .i_stop     (ch_stop[g]),
      .o_expired  (ch_expired[g]),
      .o_busy     (ch_busy[g]),
      .o_count    (ch_count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_frame_event_timer.sv
// Self-checking bench for frame_event_timer (DIV=4, CHANNELS=2, CNT_W=8): expected
// expiry tick numbers are queued at load time and matched against observed pulses.
module tb_frame_event_timer;

  localparam int unsigned DIV = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  ch_load;
  logic [15:0] ch_load_val;
  logic [1:0]  ch_periodic;
  logic [1:0]  ch_stop;
  logic        frame_tick;
  logic [1:0]  ch_expired;
  logic [1:0]  ch_busy;
  logic [15:0] ch_count;

  frame_event_timer #(
    .DIV     (DIV),
    .CHANNELS(2),
    .CNT_W   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .ch_load    (ch_load),
    .ch_load_val(ch_load_val),
    .ch_periodic(ch_periodic),
    .ch_stop    (ch_stop),
    .frame_tick (frame_tick),
    .ch_expired (ch_expired),
    .ch_busy    (ch_busy),
    .ch_count   (ch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned tick;
    bit          oneshot;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference prescaler; m_nticks counts ticks consumed by clock edges.
  int unsigned m_presc;
  logic        m_tick;
  int unsigned m_nticks;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_presc  <= DIV - 1;
      m_tick   <= 1'b0;
      m_nticks <= 0;
    end else begin
      if (m_tick) m_nticks <= m_nticks + 1;
      if (enable) begin
        if (m_presc == 0) begin
          m_presc <= DIV - 1;
          m_tick  <= 1'b1;
        end else begin
          m_presc <= m_presc - 1;
          m_tick  <= 1'b0;
        end
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  exp_t mon_e;
  bit   mon_have;

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (frame_tick !== m_tick) begin
        failures++;
        $display("FAIL frame_tick t=%0t got=%b exp=%b", $time, frame_tick, m_tick);
      end
      for (int c = 0; c < 2; c++) begin
        if (ch_expired[c]) begin
          mon_have = 1'b0;
          if (c == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
          if (c == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
          checks++;
          if (!mon_have) begin
            failures++;
            $display("FAIL unexpected_expiry ch%0d at tick=%0d exp=no_pulse", c, m_nticks);
          end else if (m_nticks !== mon_e.tick || ch_busy[c] !== !mon_e.oneshot) begin
            failures++;
            $display("FAIL expiry ch%0d got tick=%0d busy=%b exp tick=%0d busy=%b",
                     c, m_nticks, ch_busy[c], mon_e.tick, !mon_e.oneshot);
          end
        end
      end
    end
  end

  task automatic clear_q(input int c);
    if (c == 0) q0.delete(); else q1.delete();
  endtask

  task automatic push_exp(input int c, input int unsigned t, input bit oneshot);
    exp_t e;
    e.tick = t;
    e.oneshot = oneshot;
    if (c == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Drives a load over one edge; returns the consumed-tick count after that edge.
  task automatic do_load(input int c, input logic [7:0] v, input logic per,
                         input int periods, output int unsigned n0);
    ch_load[c] = 1'b1;
    ch_load_val[c*8 +: 8] = v;
    ch_periodic[c] = per;
    @(posedge clock);
    #1;
    n0 = m_nticks;
    ch_load[c] = 1'b0;
    ch_periodic[c] = 1'b0;
    clear_q(c);
    if (v != 0)
      for (int k = 1; k <= periods; k++) push_exp(c, n0 + k * v, !per);
  endtask

  task automatic do_stop(input int c, input logic with_load);
    ch_stop[c] = 1'b1;
    ch_load[c] = with_load;
    ch_load_val[c*8 +: 8] = 8'd3;
    @(posedge clock);
    #1;
    ch_stop[c] = 1'b0;
    ch_load[c] = 1'b0;
    clear_q(c);
  endtask

  task automatic wait_nticks(input int unsigned target);
    int n = 0;
    while (m_nticks < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (m_nticks < target) begin
      checks++;
      failures++;
      $display("FAIL tick_wait got=%0d exp=%0d", m_nticks, target);
    end
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_tick !== 1'b1 && n < 50);
  endtask

  task automatic test_reset;
    int n;
    #12;
    checks++;
    if ({frame_tick, ch_expired, ch_busy, ch_count} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {frame_tick, ch_expired, ch_busy, ch_count});
    end
    @(negedge clock);
    reset = 1'b1;
    cycles_to_tick(n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL first_tick got=%0d exp=4", n);
    end
  endtask

  task automatic test_prescaler;
    int n;
    cycles_to_tick(n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL tick_period got=%0d exp=4", n);
    end
    @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    n = 4;
    do begin
      @(negedge clock);
      n++;
    end while (frame_tick !== 1'b1 && n < 50);
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL tick_enable_gap got=%0d exp=7", n);
    end
  endtask

  task automatic test_oneshot;
    int unsigned n0;
    @(negedge clock);
    do_load(0, 8'd3, 1'b0, 1, n0);
    checks++;
    if (ch_busy[0] !== 1'b1 || ch_count[7:0] !== 8'd3) begin
      failures++;
      $display("FAIL oneshot_load got busy=%b cnt=%0d exp busy=1 cnt=3", ch_busy[0], ch_count[7:0]);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_nticks(n0 + k);
      checks++;
      if (ch_count[7:0] !== 8'(3 - k)) begin
        failures++;
        $display("FAIL oneshot_count step%0d got=%0d exp=%0d", k, ch_count[7:0], 3 - k);
      end
    end
    checks++;
    if (ch_busy[0] !== 1'b0 || ch_expired[0] !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_end got busy=%b exp_pulse=%b exp busy=0 pulse=1", ch_busy[0], ch_expired[0]);
    end
    @(negedge clock);
    checks++;
    if (q0.size() !== 0) begin
      failures++;
      $display("FAIL oneshot_missing got pending=%0d exp=0", q0.size());
    end
  endtask

  task automatic test_periodic;
    int unsigned n0;
    @(negedge clock);
    do_load(1, 8'd2, 1'b1, 5, n0);
    wait_nticks(n0 + 10);
    @(negedge clock);
    checks++;
    if (q1.size() !== 0) begin
      failures++;
      $display("FAIL periodic_missing got pending=%0d exp=0", q1.size());
    end
    do_stop(1, 1'b0);
    repeat (12) @(negedge clock);
    checks++;
    if (ch_busy[1] !== 1'b0 || ch_count[15:8] !== 8'd0) begin
      failures++;
      $display("FAIL periodic_stop got busy=%b cnt=%0d exp busy=0 cnt=0", ch_busy[1], ch_count[15:8]);
    end
  endtask

  task automatic test_coincident;
    int unsigned n0;
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_tick !== 1'b1 && n < 20);
    do_load(0, 8'd1, 1'b0, 1, n0);
    @(negedge clock);
    checks++;
    if (ch_busy[0] !== 1'b1 || ch_count[7:0] !== 8'd1) begin
      failures++;
      $display("FAIL coincident_load got busy=%b cnt=%0d exp busy=1 cnt=1", ch_busy[0], ch_count[7:0]);
    end
    wait_nticks(n0 + 1);
    @(negedge clock);
    checks++;
    if (q0.size() !== 0) begin
      failures++;
      $display("FAIL coincident_missing got pending=%0d exp=0", q0.size());
    end
    do_load(0, 8'd0, 1'b0, 1, n0);
    repeat (8) @(negedge clock);
    checks++;
    if (ch_busy[0] !== 1'b0 || ch_count[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL zero_load got busy=%b cnt=%0d exp busy=0 cnt=0", ch_busy[0], ch_count[7:0]);
    end
  endtask

  task automatic test_reload;
    int unsigned n0, n1;
    @(negedge clock);
    do_load(0, 8'd5, 1'b0, 1, n0);
    wait_nticks(n0 + 2);
    checks++;
    if (ch_count[7:0] !== 8'd3) begin
      failures++;
      $display("FAIL reload_mid got=%0d exp=3", ch_count[7:0]);
    end
    do_load(0, 8'd2, 1'b0, 1, n1);
    wait_nticks(n1 + 2);
    @(negedge clock);
    checks++;
    if (q0.size() !== 0) begin
      failures++;
      $display("FAIL reload_missing got pending=%0d exp=0", q0.size());
    end
    do_stop(0, 1'b1);
    repeat (20) @(negedge clock);
    checks++;
    if (ch_busy[0] !== 1'b0 || ch_count[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL stop_with_load got busy=%b cnt=%0d exp busy=0 cnt=0", ch_busy[0], ch_count[7:0]);
    end
  endtask

  task automatic test_midreset;
    int unsigned n0;
    int n;
    @(negedge clock);
    do_load(0, 8'd6, 1'b0, 1, n0);
    wait_nticks(n0 + 2);
    checks++;
    if (ch_count[7:0] !== 8'd4) begin
      failures++;
      $display("FAIL midreset_pre got=%0d exp=4", ch_count[7:0]);
    end
    @(negedge clock);
    #2;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    checks++;
    if ({frame_tick, ch_expired, ch_busy, ch_count} !== 21'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {frame_tick, ch_expired, ch_busy, ch_count});
    end
    @(negedge clock);
    reset = 1'b1;
    cycles_to_tick(n);
    checks++;
    if (n !== 4 || ch_busy !== 2'b00) begin
      failures++;
      $display("FAIL midreset_first_tick got=%0d busy=%b exp=4 busy=00", n, ch_busy);
    end
    repeat (30) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    ch_load     = '0;
    ch_load_val = '0;
    ch_periodic = '0;
    ch_stop     = '0;
    test_reset();
    test_prescaler();
    test_oneshot();
    test_periodic();
    test_coincident();
    test_reload();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
